// File: rtl/control_pkg.sv
// Shared definitions for the microcode sequencer: control-word bit map, opcode map and FSM states.
package control_pkg;

    localparam int CTRL_WORD_W = 17;

    typedef logic [CTRL_WORD_W-1:0] ctrl_t;

    // One bit per bus-attached control line; READ = load from bus, WRITE = drive bus.
    localparam ctrl_t CLK_HLT   = 17'h00001;
    localparam ctrl_t MAR_READ  = 17'h00002;
    localparam ctrl_t RAM_READ  = 17'h00004;
    localparam ctrl_t I_WRITE   = 17'h00008;
    localparam ctrl_t ALU_WRITE = 17'h00010;
    localparam ctrl_t RAM_WRITE = 17'h00020;
    localparam ctrl_t I_READ    = 17'h00040;
    localparam ctrl_t A_WRITE   = 17'h00080;
    localparam ctrl_t B_READ    = 17'h00100;
    localparam ctrl_t PC_JUMP   = 17'h00200;
    localparam ctrl_t PC_OUT    = 17'h00400;
    localparam ctrl_t PC_INC    = 17'h00800;
    localparam ctrl_t ALU_SUB   = 17'h01000;
    localparam ctrl_t A_READ    = 17'h02000;
    localparam ctrl_t B_WRITE   = 17'h04000;
    localparam ctrl_t FLAG_READ = 17'h08000;
    localparam ctrl_t OUT_EN    = 17'h10000;

    localparam logic [3:0] NOP     = 4'b0000;
    localparam logic [3:0] LOADA   = 4'b0001;
    localparam logic [3:0] ADD     = 4'b0010;
    localparam logic [3:0] SUB     = 4'b0011;
    localparam logic [3:0] STOREA  = 4'b0100;
    localparam logic [3:0] LOAD_IM = 4'b0101;
    localparam logic [3:0] JUMP    = 4'b0110;
    localparam logic [3:0] JUMPC   = 4'b0111;
    localparam logic [3:0] JUMPZ   = 4'b1000;
    localparam logic [3:0] OUT     = 4'b1110;
    localparam logic [3:0] HALT    = 4'b1111;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PAUSE  = 2'd1,
        HALTED = 2'd2
    } state_t;

endpackage

// File: rtl/control_ucode.sv
// Combinational microcode ROM: control word, last-step flag and illegal-opcode flag
// for a given opcode, micro-step and ALU flags.
module control_ucode
    import control_pkg::*;
#(
    parameter int OPCODE_W  = 4,
    parameter int MAX_STEPS = 8,
    parameter int STEP_W    = 3
) (
    input  logic [OPCODE_W-1:0]    instruction,
    input  logic [STEP_W-1:0]      step,
    input  logic                   alu_carry,
    input  logic                   alu_zero,
    output logic [CTRL_WORD_W-1:0] ctrl,
    output logic                   last,
    output logic                   illegal
);

    logic [7:0] step_x_s;
    logic [3:0] len_s;
    ctrl_t      exec_s;
    logic       illegal_s;

    assign step_x_s = 8'(step);

    // Per-opcode length (fetch included) and execute-phase control word
    always_comb begin
        len_s     = 4'd2;
        exec_s    = '0;
        illegal_s = 1'b0;
        case (instruction)
            OPCODE_W'(NOP): begin
                len_s = 4'd2;
            end
            OPCODE_W'(LOADA): begin
                len_s = 4'd4;
                if (step_x_s == 8'd2) exec_s = I_WRITE | MAR_READ;
                else if (step_x_s == 8'd3) exec_s = RAM_WRITE | A_READ;
                else exec_s = '0;
            end
            OPCODE_W'(ADD), OPCODE_W'(SUB): begin
                len_s = 4'd5;
                if (step_x_s == 8'd2) exec_s = I_WRITE | MAR_READ;
                else if (step_x_s == 8'd3) exec_s = RAM_WRITE | B_READ;
                else if (step_x_s == 8'd4 && instruction == OPCODE_W'(SUB))
                    exec_s = ALU_WRITE | ALU_SUB | A_READ | FLAG_READ;
                else if (step_x_s == 8'd4) exec_s = ALU_WRITE | A_READ | FLAG_READ;
                else exec_s = '0;
            end
            OPCODE_W'(STOREA): begin
                len_s = 4'd4;
                if (step_x_s == 8'd2) exec_s = I_WRITE | MAR_READ;
                else if (step_x_s == 8'd3) exec_s = A_WRITE | RAM_READ;
                else exec_s = '0;
            end
            OPCODE_W'(LOAD_IM): begin
                len_s = 4'd3;
                if (step_x_s == 8'd2) exec_s = I_WRITE | A_READ;
                else exec_s = '0;
            end
            OPCODE_W'(JUMP): begin
                len_s = 4'd3;
                if (step_x_s == 8'd2) exec_s = I_WRITE | PC_JUMP;
                else exec_s = '0;
            end
            OPCODE_W'(JUMPC): begin
                len_s = 4'd3;
                if (step_x_s == 8'd2 && alu_carry) exec_s = I_WRITE | PC_JUMP;
                else exec_s = '0;
            end
            OPCODE_W'(JUMPZ): begin
                len_s = 4'd3;
                if (step_x_s == 8'd2 && alu_zero) exec_s = I_WRITE | PC_JUMP;
                else exec_s = '0;
            end
            OPCODE_W'(OUT): begin
                len_s = 4'd3;
                if (step_x_s == 8'd2) exec_s = A_WRITE | OUT_EN;
                else exec_s = '0;
            end
            OPCODE_W'(HALT): begin
                len_s = 4'd3;
                if (step_x_s == 8'd2) exec_s = CLK_HLT;
                else exec_s = '0;
            end
            default: begin
                len_s     = 4'd2;
                illegal_s = 1'b1;
            end
        endcase
    end

    // Fetch overrides steps 0/1; the MAX_STEPS-1 term guarantees the counter always wraps
    always_comb begin
        if (step_x_s == 8'd0) ctrl = PC_OUT | MAR_READ;
        else if (step_x_s == 8'd1) ctrl = RAM_WRITE | I_READ | PC_INC;
        else ctrl = exec_s;
        last    = (step_x_s == 8'(len_s - 4'd1)) || (step_x_s == 8'(MAX_STEPS - 1));
        illegal = illegal_s;
    end

endmodule

// File: rtl/control_seq.sv
// Microcode sequencer: RUN/PAUSE/HALTED FSM, variable-length step counter and sticky
// illegal-opcode flag; all state changes on the falling clock edge.
module control_seq #(
    parameter int  OPCODE_W  = 4,
    parameter int  MAX_STEPS = 8,
    parameter int  CTRL_W    = 17,
    localparam int STEP_W    = $clog2(MAX_STEPS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] instruction,
    input  logic                alu_carry,
    input  logic                alu_zero,
    input  logic                step_mode,
    input  logic                step_req,
    input  logic                resume,
    output logic [CTRL_W-1:0]   ctrl_word,
    output logic [STEP_W-1:0]   step,
    output logic                instr_done,
    output logic                halted,
    output logic                illegal_op
);

    import control_pkg::*;

    state_t                 state_r;
    state_t                 state_s;
    logic [STEP_W-1:0]      step_r;
    logic [STEP_W-1:0]      step_s;
    logic                   illegal_op_r;
    logic                   illegal_op_s;
    logic [CTRL_WORD_W-1:0] uc_ctrl_s;
    logic                   uc_last_s;
    logic                   uc_illegal_s;

    control_ucode #(
        .OPCODE_W  (OPCODE_W),
        .MAX_STEPS (MAX_STEPS),
        .STEP_W    (STEP_W)
    ) u_ucode (
        .instruction (instruction),
        .step        (step_r),
        .alu_carry   (alu_carry),
        .alu_zero    (alu_zero),
        .ctrl        (uc_ctrl_s),
        .last        (uc_last_s),
        .illegal     (uc_illegal_s)
    );

    // Next state, next step and sticky illegal flag; HALT outranks step-mode pause
    always_comb begin
        state_s      = state_r;
        step_s       = step_r;
        illegal_op_s = illegal_op_r;
        case (state_r)
            RUN: begin
                if (uc_last_s) begin
                    step_s = '0;
                    if (uc_illegal_s) illegal_op_s = 1'b1;
                    else illegal_op_s = illegal_op_r;
                    if (instruction == OPCODE_W'(HALT)) state_s = HALTED;
                    else if (step_mode) state_s = PAUSE;
                    else state_s = RUN;
                end else begin
                    step_s = step_r + STEP_W'(1'b1);
                end
            end
            PAUSE: begin
                step_s = '0;
                if (step_req || !step_mode) state_s = RUN;
                else state_s = PAUSE;
            end
            HALTED: begin
                step_s = '0;
                if (resume) state_s = RUN;
                else state_s = HALTED;
            end
            default: begin
                state_s = RUN;
                step_s  = '0;
            end
        endcase
    end

    // Output gating by state; everything is forced quiet while reset is asserted
    always_comb begin
        ctrl_word  = '0;
        instr_done = 1'b0;
        halted     = 1'b0;
        if (!rst) begin
            ctrl_word = '0;
        end else begin
            case (state_r)
                RUN: begin
                    ctrl_word  = CTRL_W'(uc_ctrl_s);
                    instr_done = uc_last_s;
                end
                HALTED: begin
                    ctrl_word = CTRL_W'(CLK_HLT);
                    halted    = 1'b1;
                end
                PAUSE: begin
                    ctrl_word = '0;
                end
                default: begin
                    ctrl_word = '0;
                end
            endcase
        end
    end

    assign step       = step_r;
    assign illegal_op = illegal_op_r;

    // State registers, falling-edge clocked with synchronous active-low reset
    always_ff @(negedge clk) begin
        if (!rst) begin
            state_r      <= RUN;
            step_r       <= '0;
            illegal_op_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            step_r       <= step_s;
            illegal_op_r <= illegal_op_s;
        end
    end

endmodule

// File: doc/control_seq.md
Name: control_seq

Overview:
- Parametrised successor to the fixed 7-step microcode controller of the 8-bit CPU.
- Drives the same 17-bit control word onto the bus-attached blocks (PC, A/B, IR, MAR, RAM, ALU, OUT).
- Adds variable-length instructions, so the step counter returns to 0 right after an instruction's last step.
- Adds a HALTED state with resume, single-step (pause) mode and sticky illegal-opcode detection.

Parameters:
OPCODE_W, 4, opcode field width taken from the instruction register
MAX_STEPS, 8, hard ceiling on micro-steps per instruction; STEP_W = $clog2(MAX_STEPS)
CTRL_W, 17, control word width; bit positions defined in control_pkg

Ports:
clk  in  1  system clock; all state updates on the falling edge
rst  in  1  synchronous, active-low reset, sampled on the falling edge of clk
instruction  in  OPCODE_W  opcode bits from the IR
alu_carry  in  1  registered ALU carry flag
alu_zero  in  1  registered ALU zero flag
step_mode  in  1  1 = pause after every instruction
step_req  in  1  in PAUSE: release one instruction
resume  in  1  in HALTED: return to RUN
ctrl_word  out  CTRL_W  control signals, bit order per control_pkg (bit0 CLK_HLT … bit16 OUT_EN)
step  out  STEP_W  current micro-step
instr_done  out  1  high during the final step of an instruction (RUN only)
halted  out  1  state == HALTED
illegal_op  out  1  sticky; set when an undefined opcode completes

Behaviour:
- FSM states: RUN, PAUSE, HALTED. A registered step counter is the only other state besides illegal_op.
- Reset (rst=0 at a falling edge):
  - state=RUN, step=0, illegal_op=0.
  - While rst=0, ctrl_word=0, instr_done=0, halted=0.
  - Reset mid-instruction abandons it; the next cycle is fetch step 0.
  - Reset has priority over every other input.
- Output path: ctrl_word, instr_done and last are combinational from (state, instruction, step, flags) via control_ucode.
- Fetch (every opcode):
  - step 0: PC_OUT|MAR_READ.
  - step 1: RAM_WRITE|I_READ|PC_INC.
- Instruction lengths in cycles, fetch included:
  - NOP(0000) 2; LOADA/STOREA 4; ADD/SUB 5; LOAD_IM 3; JUMP/JUMPC/JUMPZ 3; OUT 3; HALT 3.
  - Exec step contents match the existing ISA.
- Conditional jumps:
  - At step 2, JUMPC/JUMPZ issue I_WRITE|PC_JUMP if the flag is 1, else 0.
  - Length is 3 cycles either way.
- Opcodes 1001–1101 are illegal:
  - Executed as a 2-cycle NOP.
  - illegal_op sets at the falling edge ending step 1 and holds until reset.
- RUN step transitions:
  - last=0: step+1.
  - last=1: step←0.
  - If step reaches MAX_STEPS-1, last is forced to 1 (guaranteed wrap).
- RUN state transitions at the last step:
  - opcode HALT: → HALTED.
  - else step_mode=1: → PAUSE.
  - else stay in RUN.
  - HALT takes priority over PAUSE.
- HALTED:
  - ctrl_word=CLK_HLT only; step=0; halted=1.
  - resume=1 → RUN at step 0.
  - step_req is ignored.
- PAUSE:
  - ctrl_word=0; step=0.
  - step_req=1 or step_mode=0 → RUN.
  - resume is ignored.
- In RUN, step_req and resume are ignored.
- instruction must be stable from step 2 onward (IR loaded at step 1). The block never latches the opcode.

Decomposition:
- control_pkg:
  - opcode localparams: NOP, LOADA, ADD, SUB, STOREA, LOAD_IM, JUMP, JUMPC, JUMPZ, OUT, HALT.
  - CTRL_W-wide single-bit control constants: CLK_HLT…OUT_EN.
  - state enum: RUN, PAUSE, HALTED.
- control_ucode:
  - One sub-module, purely combinational.
  - Inputs (instruction, step, alu_carry, alu_zero); outputs (ctrl, last, illegal).
- control_seq holds the FSM, step counter and illegal_op, and gates ucode outputs by state.

Test Plan:
1. Reset: rst=0 for 2 falling edges, then rst=1 → during reset ctrl_word=0x00000, step=0; first cycle after release ctrl_word=0x00402.
2. instruction=0010 (ADD), step_mode=0 → step sequence 0,1,2,3,4,0; step 4 ctrl_word=0x0A010 with instr_done=1; instr_done=0 on all other steps.
3. JUMPZ (1000):
   - alu_zero=0 → step 2 ctrl_word=0x00000, then step 0.
   - alu_zero=1 → step 2 ctrl_word=0x00208.
   - Both cases 3 cycles.
4. HALT (1111):
   - Step 2 ctrl_word=0x00001; then halted=1 and ctrl_word stays 0x00001 for 10 cycles.
   - step_req pulse has no effect.
   - resume pulse → next cycle ctrl_word=0x00402, halted=0.
5. step_mode=1, LOAD_IM (0101):
   - After step 2, PAUSE: ctrl_word=0 for 5 cycles.
   - step_req pulse → fetch step 0 (0x00402) next cycle.
6. Opcode 1010 → 2-cycle NOP, illegal_op=1 persisting through a following ADD; rst=0 at ADD step 3 → step=0 and illegal_op=0 after reset.
